// File: rtl/peak_detector.sv
// peak_detector: threshold/hysteresis peak detector for a filtered sample
// stream, with a refractory (holdoff) window and beat-to-beat interval
// measurement.
//
// Ports
//   clk           system clock, all state changes on its rising edge
//   reset         asynchronous active-low reset
//   sample_valid  one-cycle strobe per new filtered sample
//   filtered      unsigned 10-bit sample (meaningful when sample_valid=1)
//   threshold     unsigned upper detection threshold (quasi-static)
//   hysteresis    distance below threshold for the falling crossing
//   beat          one-cycle pulse per detected peak
//   peak_amp      maximum sample of the most recent detected peak
//   period        accepted-sample count between the two most recent beats
//   period_valid  period holds a valid measurement
//   busy          high while a peak is in progress or in holdoff
module peak_detector #(
  parameter int HOLDOFF = 8,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sample_valid,
  input  logic [9:0]       filtered,
  input  logic [9:0]       threshold,
  input  logic [9:0]       hysteresis,
  output logic             beat,
  output logic [9:0]       peak_amp,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             busy
);

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [7:0]       HOLD_LAST = 8'(HOLDOFF - 1);

  typedef enum logic [1:0] {
    S_BELOW = 2'd0,
    S_ABOVE = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [9:0]       max_q;
  logic [7:0]       hcnt_q;
  logic [CNT_W-1:0] cnt_q;
  logic             prior_q;

  logic [9:0]       lo;
  logic [CNT_W-1:0] cnt_inc;
  logic             start, term, hold_done, beat_evt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
    return (x == CNT_MAX) ? x : x + CNT_W'(1);
  endfunction

  function automatic logic [9:0] sat_sub(input logic [9:0] a, input logic [9:0] b);
    return (a >= b) ? a - b : 10'd0;
  endfunction

  assign lo        = sat_sub(threshold, hysteresis);
  assign cnt_inc   = sat_inc(cnt_q);
  assign start     = (state_q == S_BELOW) && (filtered >= threshold);
  assign term      = (state_q == S_ABOVE) && (filtered < lo);
  assign hold_done = (state_q == S_HOLD) && (hcnt_q == HOLD_LAST);
  assign beat_evt  = sample_valid && term;
  assign busy      = (state_q != S_BELOW);

  always_comb begin
    state_d = state_q;
    if (sample_valid) begin
      case (state_q)
        S_BELOW: if (start)     state_d = S_ABOVE;
        S_ABOVE: if (term)      state_d = S_HOLD;
        S_HOLD:  if (hold_done) state_d = S_BELOW;
        default:                state_d = S_BELOW;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_BELOW;
    else        state_q <= state_d;
  end

  // Registered outputs: beat and captures appear the cycle after the
  // terminating sample.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      beat         <= 1'b0;
      peak_amp     <= '0;
      period       <= '0;
      period_valid <= 1'b0;
      max_q        <= '0;
      hcnt_q       <= '0;
      cnt_q        <= '0;
      prior_q      <= 1'b0;
    end else begin
      beat <= beat_evt;
      if (sample_valid) begin
        if (start)
          max_q <= filtered;
        else if (state_q == S_ABOVE && !term && filtered > max_q)
          max_q <= filtered;

        if (term)
          hcnt_q <= '0;
        else if (state_q == S_HOLD)
          hcnt_q <= hcnt_q + 8'd1;

        if (term) begin
          peak_amp <= max_q;
          // A period is only meaningful once an earlier beat is on record.
          if (prior_q) begin
            period       <= cnt_inc;
            period_valid <= 1'b1;
          end
          prior_q <= 1'b1;
          cnt_q   <= '0;
        end else begin
          cnt_q <= cnt_inc;
          // Interval too long to measure: forget the earlier beat.
          if (cnt_inc == CNT_MAX) begin
            prior_q      <= 1'b0;
            period_valid <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: doc/peak_detector.md
PEAK_DETECTOR -- requirements
Module: peak_detector

Interface
REQ-001 Parameter HOLDOFF, default 8: number of accepted samples ignored after each beat (refractory period), legal range 1..255.
REQ-002 Parameter CNT_W, default 16: width of the inter-beat sample counter and period output.
REQ-003 clk  input  1  single system clock; all state changes on posedge clk.
REQ-004 reset  input  1  asynchronous, active-low reset; asserting (0) clears all state immediately, deassertion synchronous to clk.
REQ-005 sample_valid  input  1  strobe, one clk cycle per new filtered sample from the upstream FIR stage.
REQ-006 filtered  input  10  unsigned filtered sample, meaningful only when sample_valid=1.
REQ-007 threshold  input  10  unsigned upper detection threshold; quasi-static.
REQ-008 hysteresis  input  10  unsigned hysteresis below threshold for the falling crossing; quasi-static.
REQ-009 beat  output  1  one-cycle pulse per detected peak.
REQ-010 peak_amp  output  10  maximum sample value of the most recent detected peak.
REQ-011 period  output  CNT_W  accepted-sample count between the two most recent beats.
REQ-012 period_valid  output  1  period holds a valid measurement.
REQ-013 busy  output  1  high while state is ABOVE or HOLDOFF.

Function
REQ-014 Only cycles with sample_valid=1 advance the FSM, counters or peak tracking; all other cycles hold state.
REQ-015 Low threshold lo = threshold - hysteresis, saturating at 0 (hysteresis > threshold gives lo=0).
REQ-016 FSM states: BELOW, ABOVE, HOLDOFF; reset state BELOW.
REQ-017 BELOW: accepted sample >= threshold -> ABOVE, running max <= sample; else stay.
REQ-018 ABOVE: accepted sample > running max -> running max <= sample; accepted sample < lo -> HOLDOFF and beat event; else stay.
REQ-019 Beat event: beat=1 on the clk cycle following the terminating accepted sample (1-cycle registered latency), peak_amp <= running max in that same cycle.
REQ-020 beat is exactly one clk cycle wide regardless of sample_valid spacing.
REQ-021 HOLDOFF: counts accepted samples; after HOLDOFF accepted samples -> BELOW; samples in HOLDOFF never start a peak, even if >= threshold.
REQ-022 Interval counter: on each accepted sample, saturating increment by 1 at 2^CNT_W-1; on a beat-event sample, counter <= 0 after capture.
REQ-023 On a beat event with a prior beat recorded: period <= counter+1 (saturated), period_valid <= 1.
REQ-024 First beat after reset or after timeout records a prior beat only; period and period_valid unchanged.
REQ-025 Timeout: counter reaching 2^CNT_W-1 clears the prior-beat flag and sets period_valid <= 0; period holds last value.
REQ-026 Arithmetic unsigned throughout; comparisons full 10-bit; no wrap-around on any counter.
REQ-027 threshold=0: every accepted sample in BELOW enters ABOVE (legal, no special case).

Reset
REQ-028 reset=0: state BELOW, beat=0, peak_amp=0, period=0, period_valid=0, busy=0, counters and running max 0, prior-beat flag cleared.
REQ-029 reset asserted mid-peak (ABOVE or HOLDOFF) discards the peak in progress; no beat issued after release.
REQ-030 First accepted sample after reset release is processed normally in BELOW.

Verification
REQ-031 threshold=500, hysteresis=50, samples 100,600,700,650,400 (valid every 4 clk) -> one beat 1 clk after sample 400, peak_amp=700, period_valid stays 0.
REQ-032 Same peak repeated with 20 accepted samples between terminating samples -> second beat gives period=20, period_valid=1.
REQ-033 Samples oscillate 480..520 around threshold=500, hysteresis=50 -> exactly one entry to ABOVE, no beat until a sample < 450.
REQ-034 HOLDOFF=8, sample >= threshold 3 samples after a beat -> ignored; same value 9 samples after beat -> new peak starts.
REQ-035 CNT_W=8, no beat for 255 accepted samples after a valid period -> period_valid=0; next beat gives no period update, the following does.
REQ-036 reset pulsed low while in ABOVE with running max 900 -> all outputs 0 immediately, no beat after release, peak_amp=0.
